// File: rtl/bullets_manager.sv
//------------------------------------------------------------------------------
// Module      : bullets_manager
// Description : Fixed pool of player bullets. Spawns a bullet at the shooter
//               position on a fire edge, moves active bullets up once per
//               frame, retires them on top-edge exit or hit, and produces the
//               registered per-slot drawing requests and bullet colour.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bullets_manager #(
    parameter int          NUM_BULLETS     = 3,
    parameter int          BULLET_W        = 4,
    parameter int          BULLET_H        = 8,
    parameter int          SPEED           = 6,
    parameter int          COOLDOWN_FRAMES = 10,
    parameter logic [7:0]  BULLET_COLOR    = 8'hFC,
    localparam int         CNT_W           = $clog2(NUM_BULLETS + 1)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic [10:0]            pixelX,
    input  logic [10:0]            pixelY,
    input  logic                   fireRequest,
    input  logic [10:0]            shooterX,
    input  logic [10:0]            shooterY,
    input  logic [NUM_BULLETS-1:0] bulletHit,
    output logic [NUM_BULLETS-1:0] bulletDrawingRequest,
    output logic [7:0]             bulletRGB,
    output logic                   fireAccepted,
    output logic [CNT_W-1:0]       activeCount
);

    localparam int          CD_W       = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] c_COOLDOWN = CD_W'(COOLDOWN_FRAMES);
    localparam logic [10:0] c_SPEED    = 11'(SPEED);
    localparam logic [11:0] c_W12      = 12'(BULLET_W);
    localparam logic [11:0] c_H12      = 12'(BULLET_H);

    logic [NUM_BULLETS-1:0] w_active;       // current active flags
    logic [NUM_BULLETS-1:0] w_active_nxt;   // active flags after this clock
    logic [NUM_BULLETS-1:0] w_inside;       // current pixel inside slot i
    logic [NUM_BULLETS-1:0] w_free_sel;     // one-hot lowest free slot
    logic [NUM_BULLETS-1:0] w_grant;        // one-hot slot being allocated
    logic                   w_any_free;
    logic                   w_fire_edge;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [11:0]            w_px;
    logic [11:0]            w_py;

    logic                   r_fire_prev;
    logic [CD_W-1:0]        r_cooldown;

    // Widen the scan position so X+W and Y+H never wrap in the compares.
    assign w_px = {1'b0, pixelX};
    assign w_py = {1'b0, pixelY};

    assign w_fire_edge = fireRequest & ~r_fire_prev;

    // Lowest-index free slot, judged on the flags before this clock so a slot
    // freed by a hit this cycle only becomes allocatable next cycle.
    always_comb begin
        w_free_sel = '0;
        w_any_free = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!w_active[i] && !w_any_free) begin
                w_free_sel[i] = 1'b1;
                w_any_free    = 1'b1;
            end
        end
    end

    // The cooldown seen here is the value before any same-cycle decrement.
    assign w_accept = w_fire_edge && (r_cooldown == '0) && w_any_free;
    assign w_grant  = w_accept ? w_free_sel : '0;

    // Per-slot state: allocation wins, then hit, then per-frame motion.
    for (genvar gi = 0; gi < NUM_BULLETS; gi++) begin : g_slot
        logic        r_act;
        logic [10:0] r_x;
        logic [10:0] r_y;
        logic        w_act_nxt;
        logic [10:0] w_x_nxt;
        logic [10:0] w_y_nxt;
        logic [11:0] w_x12;
        logic [11:0] w_y12;

        // Next-state selection for one slot.
        always_comb begin
            w_act_nxt = r_act;
            w_x_nxt   = r_x;
            w_y_nxt   = r_y;
            if (w_grant[gi]) begin
                w_act_nxt = 1'b1;
                w_x_nxt   = shooterX;
                w_y_nxt   = shooterY;
            end else if (bulletHit[gi]) begin
                w_act_nxt = 1'b0;
            end else if (startOfFrame && r_act) begin
                if (r_y < c_SPEED) begin
                    w_act_nxt = 1'b0;
                end else begin
                    w_y_nxt = r_y - c_SPEED;
                end
            end
        end

        // Slot registers.
        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_act <= 1'b0;
                r_x   <= '0;
                r_y   <= '0;
            end else begin
                r_act <= w_act_nxt;
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
            end
        end

        assign w_x12            = {1'b0, r_x};
        assign w_y12            = {1'b0, r_y};
        assign w_active[gi]     = r_act;
        assign w_active_nxt[gi] = w_act_nxt;
        assign w_inside[gi]     = r_act
                                  && (w_px >= w_x12) && (w_px < w_x12 + c_W12)
                                  && (w_py >= w_y12) && (w_py < w_y12 + c_H12);
    end

    // Popcount of the flags being written, so activeCount tracks the slots.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_count_nxt = w_count_nxt + CNT_W'(w_active_nxt[i]);
        end
    end

    // Fire edge detector and shot cooldown counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_fire_prev <= 1'b0;
            r_cooldown  <= '0;
        end else begin
            r_fire_prev <= fireRequest;
            if (w_accept) begin
                r_cooldown <= c_COOLDOWN;
            end else if (startOfFrame && (r_cooldown != '0)) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end
        end
    end

    // Registered outputs: one cycle of latency from the scan position.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bulletDrawingRequest <= '0;
            bulletRGB            <= 8'h00;
            fireAccepted         <= 1'b0;
            activeCount          <= '0;
        end else begin
            bulletDrawingRequest <= w_inside;
            bulletRGB            <= (|w_inside) ? BULLET_COLOR : 8'h00;
            fireAccepted         <= w_accept;
            activeCount          <= w_count_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bullets_manager.sv
//------------------------------------------------------------------------------
// Module      : tb_bullets_manager
// Description : Self-checking bench for bullets_manager with a behavioural
//               bullet-pool model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bullets_manager;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        fireRequest = 1'b0;
    logic [10:0] shooterX = '0;
    logic [10:0] shooterY = '0;
    logic [2:0]  bulletHit = '0;
    logic [2:0]  bulletDrawingRequest;
    logic [7:0]  bulletRGB;
    logic        fireAccepted;
    logic [1:0]  activeCount;

    always #5 clk = ~clk;

    bullets_manager dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .fireRequest          (fireRequest),
        .shooterX             (shooterX),
        .shooterY             (shooterY),
        .bulletHit            (bulletHit),
        .bulletDrawingRequest (bulletDrawingRequest),
        .bulletRGB            (bulletRGB),
        .fireAccepted         (fireAccepted),
        .activeCount          (activeCount)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the pool.
    int m_act[3];
    int m_x[3];
    int m_y[3];
    int m_cd;
    int m_prev;
    int e_req, e_rgb, e_acc, e_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0; m_prev = 0;
        e_req = 0; e_rgb = 0; e_acc = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        int req;
        int free;
        int acc;
        int px, py;
        req  = 0;
        free = -1;
        px   = int'(pixelX);
        py   = int'(pixelY);
        for (int i = 0; i < 3; i++) begin
            if (m_act[i] != 0 && px >= m_x[i] && px < m_x[i] + 4 &&
                py >= m_y[i] && py < m_y[i] + 8)
                req = req | (1 << i);
            if (m_act[i] == 0 && free < 0) free = i;
        end
        acc = (fireRequest && m_prev == 0 && m_cd == 0 && free >= 0) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            if (acc != 0 && i == free) begin
                m_act[i] = 1; m_x[i] = int'(shooterX); m_y[i] = int'(shooterY);
            end else if (bulletHit[i]) begin
                m_act[i] = 0;
            end else if (startOfFrame && m_act[i] != 0) begin
                if (m_y[i] < 6) m_act[i] = 0;
                else m_y[i] = m_y[i] - 6;
            end
        end
        if (acc != 0) m_cd = 10;
        else if (startOfFrame && m_cd > 0) m_cd = m_cd - 1;
        m_prev = int'(fireRequest);
        e_req = req;
        e_rgb = (req != 0) ? 'hFC : 0;
        e_acc = acc;
        e_cnt = m_act[0] + m_act[1] + m_act[2];
    endtask

    task automatic compare();
        chk("drawReq",     int'(bulletDrawingRequest), e_req);
        chk("rgb",         int'(bulletRGB),            e_rgb);
        chk("fireAccepted", int'(fireAccepted),        e_acc);
        chk("activeCount", int'(activeCount),          e_cnt);
    endtask

    // One clock: model advances at the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!resetN) model_reset();
        else model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            startOfFrame = 1'b1; tick();
            startOfFrame = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0; tick(); tick();
        resetN = 1'b1;
    endtask

    initial begin
        int v;
        model_reset();

        // Reset state.
        resetN = 1'b0;
        repeat (3) tick();
        chk("rst_req", int'(bulletDrawingRequest), 0);
        chk("rst_rgb", int'(bulletRGB), 0);
        chk("rst_cnt", int'(activeCount), 0);
        resetN = 1'b1;
        tick();

        // First shot at (300,400).
        shooterX = 11'd300; shooterY = 11'd400; fireRequest = 1'b1;
        tick();
        chk("shot1_acc", int'(fireAccepted), 1);
        chk("shot1_cnt", int'(activeCount), 1);
        chk("model_slot0_x", m_x[0], 300);

        // Holding fire high does not re-fire.
        tick();
        chk("hold_acc", int'(fireAccepted), 0);
        fireRequest = 1'b0;

        // Pixel scan corners and just outside.
        pixelX = 11'd300; pixelY = 11'd400; tick();
        chk("draw_tl_req", int'(bulletDrawingRequest), 1);
        chk("draw_tl_rgb", int'(bulletRGB), 'hFC);
        pixelX = 11'd303; pixelY = 11'd407; tick();
        chk("draw_br_req", int'(bulletDrawingRequest), 1);
        pixelX = 11'd304; pixelY = 11'd400; tick();
        chk("draw_out_req", int'(bulletDrawingRequest), 0);
        chk("draw_out_rgb", int'(bulletRGB), 0);

        // Edge within cooldown is ignored.
        fireRequest = 1'b1; tick();
        chk("cool_acc", int'(fireAccepted), 0);
        fireRequest = 1'b0; tick();

        // Three shots 10 frames apart, then a fourth edge with the pool full.
        frames(10);
        fireRequest = 1'b1; tick();
        chk("shot2_acc", int'(fireAccepted), 1);
        chk("shot2_cnt", int'(activeCount), 2);
        fireRequest = 1'b0; tick();
        frames(10);
        fireRequest = 1'b1; tick();
        chk("shot3_acc", int'(fireAccepted), 1);
        chk("shot3_cnt", int'(activeCount), 3);
        fireRequest = 1'b0; tick();
        frames(10);
        fireRequest = 1'b1; tick();
        chk("shot4_acc", int'(fireAccepted), 0);
        chk("shot4_cnt", int'(activeCount), 3);
        fireRequest = 1'b0; tick();

        // Hit on slot1 coinciding with a frame start.
        bulletHit = 3'b010; startOfFrame = 1'b1; tick();
        chk("hitsof_cnt", int'(activeCount), 2);
        bulletHit = 3'b000; startOfFrame = 1'b0;
        fireRequest = 1'b1; tick();
        chk("realloc_acc", int'(fireAccepted), 1);
        chk("realloc_cnt", int'(activeCount), 3);
        fireRequest = 1'b0;
        // slot0: 400 - 31*6 = 214, slot2: 400 - 11*6 = 334, slot1 fresh at 400
        pixelX = 11'd300; pixelY = 11'd214; tick();
        chk("slot0_pos", int'(bulletDrawingRequest), 1);
        pixelY = 11'd334; tick();
        chk("slot2_pos", int'(bulletDrawingRequest), 4);
        pixelY = 11'd400; tick();
        chk("slot1_pos", int'(bulletDrawingRequest), 2);

        // Asynchronous reset while drawing.
        #2 resetN = 1'b0;
        #1;
        chk("async_req", int'(bulletDrawingRequest), 0);
        chk("async_rgb", int'(bulletRGB), 0);
        chk("async_cnt", int'(activeCount), 0);
        tick();
        resetN = 1'b1; tick();
        chk("post_rst_cnt", int'(activeCount), 0);

        // Top exit at Y=5.
        shooterX = 11'd100; shooterY = 11'd5; fireRequest = 1'b1; tick();
        fireRequest = 1'b0; startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk("exit5_cnt", int'(activeCount), 0);

        // Y=6 moves to 0 and stays active.
        do_reset();
        shooterY = 11'd6; fireRequest = 1'b1; tick();
        fireRequest = 1'b0; startOfFrame = 1'b1; tick();
        startOfFrame = 1'b0;
        chk("y6_cnt", int'(activeCount), 1);
        pixelX = 11'd100; pixelY = 11'd0; tick();
        chk("y6_draw", int'(bulletDrawingRequest), 1);
        pixelY = 11'd8; tick();
        chk("y6_below", int'(bulletDrawingRequest), 0);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 20000; c++) begin
            resetN = ($urandom_range(0, 3999) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 2) == 0) fireRequest = ~fireRequest;
            startOfFrame = ($urandom_range(0, 7) == 0);
            bulletHit    = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            shooterX     = 11'($urandom_range(0, 639));
            shooterY     = 11'($urandom_range(0, 479));
            if ($urandom_range(0, 1) == 0) begin
                int k;
                k = $urandom_range(0, 2);
                v = m_x[k] + $urandom_range(0, 5) - 1;
                pixelX = 11'((v < 0) ? 0 : v);
                v = m_y[k] + $urandom_range(0, 9) - 1;
                pixelY = 11'((v < 0) ? 0 : v);
            end else begin
                pixelX = 11'($urandom_range(0, 639));
                pixelY = 11'($urandom_range(0, 479));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
